// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: shares one memory bus between fetch and load/store, data first with bounded insn starvation.
// Define CORE_BUS_ARB_LOCK_EN to add data_lock, which keeps the bus on the data port for atomic sequences.
module core_bus_arbiter #(
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        insn_req,
   input  logic [29:0] insn_addr,
   output logic        insn_ready,
   output logic [31:0] insn_data,
   input  logic        data_req,
   input  logic        data_write,
   input  logic [29:0] data_addr,
   input  logic [31:0] data_wdata,
`ifdef CORE_BUS_ARB_LOCK_EN
   input  logic        data_lock,
`endif
   output logic        data_ready,
   output logic [31:0] data_rdata,
   output logic [29:0] bus_addr,
   output logic        bus_start,
   output logic        bus_write,
   input  logic        bus_ready,
   input  logic [31:0] bus_data_rd,
   output logic [31:0] bus_data_wr,
   output logic        bus_owner
);
   localparam int SW = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
   localparam logic [SW-1:0] MAX_S = SW'(MAX_DATA_STREAK);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state_q, state_d;
   logic [SW-1:0] streak_q, streak_d;
   logic owner_q, owner_d, write_q, write_d, start_q, start_d;
   logic [29:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic locked, insn_cand, force_insn, pick_data;
`ifdef CORE_BUS_ARB_LOCK_EN
   logic lock_q, lock_d;
   assign locked = lock_q & data_lock;
`else
   assign locked = 1'b0;
`endif
   // A held lock hides the fetch request entirely, so it neither wins nor advances the streak.
   assign insn_cand  = insn_req & ~locked;
   assign force_insn = (MAX_DATA_STREAK != 0) && (streak_q == MAX_S);
   assign pick_data  = data_req & ~(insn_cand & force_insn);
   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      owner_d  = owner_q;
      addr_d   = addr_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      start_d  = 1'b0;
`ifdef CORE_BUS_ARB_LOCK_EN
      lock_d   = lock_q;
      if (state_q == IDLE && !data_lock) lock_d = 1'b0;
      if (state_q == BUSY && bus_ready && owner_q && data_lock) lock_d = 1'b1;
`endif
      if (state_q == IDLE && (data_req || insn_cand)) begin
         state_d  = BUSY;
         start_d  = 1'b1;
         owner_d  = pick_data;
         addr_d   = pick_data ? data_addr : insn_addr;
         write_d  = pick_data & data_write;
         wdata_d  = pick_data ? data_wdata : wdata_q;
         streak_d = locked ? streak_q
                  : (pick_data && insn_cand) ? ((streak_q == MAX_S) ? streak_q : streak_q + 1'b1)
                  : '0;
      end else if (state_q == BUSY && bus_ready) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         streak_q <= '0;
         owner_q  <= 1'b0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         start_q  <= 1'b0;
`ifdef CORE_BUS_ARB_LOCK_EN
         lock_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         owner_q  <= owner_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         start_q  <= start_d;
`ifdef CORE_BUS_ARB_LOCK_EN
         lock_q   <= lock_d;
`endif
      end
   end
   assign bus_start   = start_q;
   assign bus_addr    = addr_q;
   assign bus_write   = write_q;
   assign bus_data_wr = wdata_q;
   assign bus_owner   = owner_q;
   assign insn_ready  = (state_q == BUSY) & ~owner_q & bus_ready;
   assign data_ready  = (state_q == BUSY) & owner_q & bus_ready;
   assign insn_data   = bus_data_rd;
   assign data_rdata  = bus_data_rd;
endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Shares the core's single memory bus between the instruction-fetch port and the load/store data port.
- Serialises transactions and latches the winner's address, write flag and write data for the whole transaction.
- Issues a one-cycle bus_start and routes bus_ready and bus_data_rd back to the owning requester.
- Fixed data-over-instruction priority, with a streak counter that bounds instruction starvation.

Parameters:
- MAX_DATA_STREAK, 4: max consecutive data grants made while insn_req is pending before insn is forced; 0 = unlimited (pure data priority).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
insn_req  in  1  fetch request, held until insn_ready
insn_addr  in  30  fetch word address (ptr)
insn_ready  out  1  one-cycle completion pulse to fetch
insn_data  out  32  read data, valid with insn_ready
data_req  in  1  load/store request, held until data_ready
data_write  in  1  1 = store
data_addr  in  30  data word address (ptr)
data_wdata  in  32  store data
data_ready  out  1  one-cycle completion pulse to data port
data_rdata  out  32  read data, valid with data_ready
bus_addr  out  30  bus word address
bus_start  out  1  one-cycle transaction start
bus_write  out  1  bus write strobe
bus_ready  in  1  bus completion
bus_data_rd  in  32  bus read data
bus_data_wr  out  32  bus write data
bus_owner  out  1  0 = insn, 1 = data; valid in BUSY

Behaviour:
- Single clock clk; asynchronous active-low reset rst_n.
- Reset values:
  - state = IDLE, streak = 0.
  - bus_start, bus_write, bus_owner, insn_ready and data_ready = 0.
  - bus_addr and bus_data_wr = 0.
- insn_data and data_rdata are combinational copies of bus_data_rd.
- IDLE state; arbitration on a clock edge where at least one request is high:
  - Only data_req high: grant data.
  - Only insn_req high: grant insn.
  - Both high: grant insn if MAX_DATA_STREAK != 0 and streak == MAX_DATA_STREAK; otherwise grant data.
- On grant:
  - Register owner, bus_addr and bus_write (data_write for data, 0 for insn).
  - Register bus_data_wr (data_wdata for data; unchanged for insn).
  - Set bus_start = 1 for exactly the next cycle and enter BUSY.
  - Latency: request sampled at edge N, bus_start high in cycle N+1.
- Streak update at grant:
  - Data grant with insn_req high: streak += 1, saturating at MAX_DATA_STREAK.
  - Insn grant, or data grant with insn_req low: streak = 0.
  - Counter width is clog2(MAX_DATA_STREAK+1), minimum 1.
- BUSY state:
  - bus_addr, bus_write, bus_data_wr and bus_owner are held stable.
  - bus_ready is honoured in every BUSY cycle, including the bus_start cycle.
  - In the bus_ready cycle, the owner's ready output equals bus_ready combinationally; the other ready output stays 0.
  - Next state after bus_ready is IDLE.
- bus_ready in IDLE is ignored: no ready pulse and no state change.
- Requesters:
  - Sample their ready pulse and update req by the next edge.
  - req still high in the following IDLE cycle is a new transaction.
  - Request inputs of the non-owner are ignored during BUSY and may change freely.
  - Changing the owner's address or data during BUSY has no effect, since the values are latched.
- Back-to-back transactions: minimum 2 cycles from one bus_ready to the next bus_start (ready cycle, then IDLE arbitration cycle).
- Reset mid-BUSY: return to IDLE immediately. The abandoned bus transaction's later bus_ready is ignored per the IDLE rule.

Optional Feature:
- Macro: CORE_BUS_ARB_LOCK_EN.
- When defined:
  - Adds input data_lock (1 bit).
  - A data transaction that completes with data_lock high sets a lock flag (reset value 0).
  - While the flag is set, IDLE considers only data_req; insn_req is not granted and streak is frozen.
  - The flag clears in any IDLE cycle where data_lock is low, and arbitration proceeds normally in that same cycle.
  - Used for atomic SWP read-then-write.
- When undefined: the port is absent and arbitration follows the base rules only.

Test Plan:
- Insn only: insn_req=1, insn_addr=0x100; bus_ready 2 cycles after bus_start with bus_data_rd=0xE3A00001 -> bus_start 1 cycle after req, bus_addr=0x100, bus_write=0; insn_ready pulses with insn_data=0xE3A00001; data_ready stays 0.
- Simultaneous: insn_req and data_req both high, data_write=1, data_addr=0x40, data_wdata=0xDEADBEEF -> data granted first with bus_write=1 and bus_data_wr=0xDEADBEEF; insn granted second; bus_owner 1 then 0.
- Starvation: MAX_DATA_STREAK=4, data_req and insn_req held high, zero-wait bus -> grant order D,D,D,D,I,D,D,D,D,I.
- Stability: change data_addr to 0x7 mid-BUSY; assert bus_ready in the bus_start cycle -> bus_addr keeps its latched value; data_ready pulses in that same cycle; next bus_start appears no earlier than 2 cycles later.
- Reset: assert rst_n=0 mid-BUSY, release, then pulse bus_ready -> all outputs 0 during reset; no ready pulse afterwards; state IDLE.
- Lock (CORE_BUS_ARB_LOCK_EN): data read completes with data_lock=1 while insn_req=1 -> insn not granted; the following data write is granted; insn is granted only after data_lock drops.
